// File: rtl/mem_stage.sv
// mem_stage: memory-access stage with req/ack data-memory port,
// hardware call/return stack and registered MEM/WB fields.
module mem_stage #(
   parameter int                ADDR_W     = 12,
   parameter int                DATA_W     = 32,
   parameter logic [ADDR_W-1:0] STACK_TOP  = 12'hFFF,
   parameter logic [ADDR_W-1:0] STACK_BASE = 12'hF00
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              RegWrite_in,
   input  logic              MemWrite_in,
   input  logic              MemRead_in,
   input  logic              MemToReg_in,
   input  logic              MemSrc_in,
   input  logic              call_in,
   input  logic              ret_in,
   input  logic [4:0]        DestReg_in,
   input  logic [31:0]       ALU_addr_in,
   input  logic [11:0]       NON_ALU_addr_in,
   input  logic [31:0]       MemWrite_data_in,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_ack,
   output logic              stall,
   output logic              RegWrite_out,
   output logic [4:0]        DestReg_out,
   output logic [31:0]       wb_data,
   output logic              ret_valid,
   output logic [31:0]       ret_addr,
   output logic              stack_err
);

   typedef enum logic {S_IDLE, S_WAIT} state_e;
   typedef enum logic [2:0] {
      OP_NONE, OP_PUSH, OP_POP, OP_STORE, OP_LOAD
   } op_e;

   state_e              state_q;
   op_e                 op, op_q;
   logic [ADDR_W-1:0]   sp_q, addr_sel;
   logic                suppress, mem_op;
   logic                req_q, we_q, rw_q, rv_q, err_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [4:0]          dest_q;
   logic [31:0]         wb_q, ra_q;

   // Operation class; call wins over ret, ret over store, store over load
   always_comb begin
      op = OP_NONE;
      priority case (1'b1)
         call_in:     op = OP_PUSH;
         ret_in:      op = OP_POP;
         MemWrite_in: op = OP_STORE;
         MemRead_in:  op = OP_LOAD;
         default:     op = OP_NONE;
      endcase
   end

   // Address select, stack bound checks and combinational stall
   always_comb begin
      addr_sel = MemSrc_in ? ADDR_W'(NON_ALU_addr_in)
                           : ALU_addr_in[ADDR_W-1:0];
      suppress = (op == OP_PUSH && sp_q == STACK_BASE) ||
                 (op == OP_POP  && sp_q == STACK_TOP);
      mem_op   = (op != OP_NONE) && !suppress;
      if (rst)
         stall = 1'b0;
      else if (state_q == S_IDLE)
         stall = mem_op;
      else
         stall = !dmem_ack;
   end

   // Two-state access FSM with registered memory and MEM/WB outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= OP_NONE;
         sp_q    <= STACK_TOP;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rw_q    <= 1'b0;
         dest_q  <= '0;
         wb_q    <= '0;
         rv_q    <= 1'b0;
         ra_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         rv_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (mem_op) begin
                  state_q <= S_WAIT;
                  op_q    <= op;
                  req_q   <= 1'b1;
                  we_q    <= (op == OP_PUSH) || (op == OP_STORE);
                  wdata_q <= DATA_W'(MemWrite_data_in);
                  rw_q    <= 1'b0;
                  if (op == OP_PUSH)
                     addr_q <= sp_q - ADDR_W'(1);
                  else if (op == OP_POP)
                     addr_q <= sp_q;
                  else
                     addr_q <= addr_sel;
                  if (call_in && ret_in)
                     err_q <= 1'b1;
               end else begin
                  rw_q   <= (op == OP_NONE) ? RegWrite_in : 1'b0;
                  dest_q <= DestReg_in;
                  wb_q   <= ALU_addr_in;
                  if (suppress)
                     err_q <= 1'b1;
               end
            end
            S_WAIT: begin
               if (dmem_ack) begin
                  state_q <= S_IDLE;
                  req_q   <= 1'b0;
                  dest_q  <= DestReg_in;
                  rw_q    <= RegWrite_in;
                  wb_q    <= (op_q == OP_LOAD && MemToReg_in)
                             ? 32'(dmem_rdata) : ALU_addr_in;
                  if (op_q == OP_PUSH)
                     sp_q <= sp_q - ADDR_W'(1);
                  if (op_q == OP_POP) begin
                     sp_q <= sp_q + ADDR_W'(1);
                     ra_q <= 32'(dmem_rdata);
                     rv_q <= 1'b1;
                     rw_q <= 1'b0;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign dmem_req     = req_q;
   assign dmem_we      = we_q;
   assign dmem_addr    = addr_q;
   assign dmem_wdata   = wdata_q;
   assign RegWrite_out = rw_q;
   assign DestReg_out  = dest_q;
   assign wb_data      = wb_q;
   assign ret_valid    = rv_q;
   assign ret_addr     = ra_q;
   assign stack_err    = err_q;

endmodule
